// File: rtl/addr_decoder_pkg.sv
// -----------------------------------------------------------------------------
// addr_decoder_pkg
// Shared definitions for the CPU address decoder:
//   - BRAM channel indices and channel count
//   - region_t : every decoded region of the 15-bit CPU address map
//   - base/limit constants for each region, plus a range helper
// -----------------------------------------------------------------------------
package addr_decoder_pkg;

  localparam int NUM_CH      = 5;
  localparam int CH_PROG_ROM = 0;
  localparam int CH_PROG_RAM = 1;
  localparam int CH_VECTOR   = 2;
  localparam int CH_MATH     = 3;
  localparam int CH_POKEY    = 4;

  typedef enum logic [3:0] {
    REG_UNMAPPED,
    REG_PROG_RAM,
    REG_IN0,
    REG_DSW0,
    REG_DSW1,
    REG_VGGO,
    REG_VGRST,
    REG_MATH_RD,
    REG_POKEY,
    REG_MATH_WR,
    REG_VECTOR,
    REG_PROG_ROM
  } region_t;

  localparam logic [14:0] PROG_RAM_BASE  = 15'h0000, PROG_RAM_LIMIT  = 15'h07FF;
  localparam logic [14:0] IN0_BASE       = 15'h0800, IN0_LIMIT       = 15'h09FF;
  localparam logic [14:0] DSW0_BASE      = 15'h0A00, DSW0_LIMIT      = 15'h0BFF;
  localparam logic [14:0] DSW1_BASE      = 15'h0C00, DSW1_LIMIT      = 15'h0DFF;
  localparam logic [14:0] VGGO_BASE      = 15'h1200, VGGO_LIMIT      = 15'h13FF;
  localparam logic [14:0] VGRST_BASE     = 15'h1600, VGRST_LIMIT     = 15'h17FF;
  localparam logic [14:0] MATH_RD_BASE   = 15'h1800, MATH_RD_LIMIT   = 15'h181F;
  localparam logic [14:0] POKEY_BASE     = 15'h1820, POKEY_LIMIT     = 15'h185F;
  localparam logic [14:0] MATH_WR_BASE   = 15'h1860, MATH_WR_LIMIT   = 15'h187F;
  localparam logic [14:0] VECTOR_BASE    = 15'h2000, VECTOR_LIMIT    = 15'h3FFF;
  // Only the lower half of vector memory is RAM; the upper half is ROM.
  localparam logic [14:0] VECTOR_WR_LIMIT = 15'h2FFF;
  localparam logic [14:0] PROG_ROM_BASE  = 15'h5000, PROG_ROM_LIMIT  = 15'h7FFF;

  function automatic logic in_range(input logic [14:0] a,
                                    input logic [14:0] lo,
                                    input logic [14:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/addr_region_decode.sv
// -----------------------------------------------------------------------------
// addr_region_decode
// Pure combinational map from CPU address to region. Bit 15 is ignored.
// Ports:
//   addr   in  16  CPU address
//   region out     decoded region (REG_UNMAPPED when nothing matches)
// -----------------------------------------------------------------------------
module addr_region_decode
  import addr_decoder_pkg::*;
(
  input  logic [15:0] addr,
  output region_t     region
);

  logic [14:0] a;
  assign a = addr[14:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    region = REG_UNMAPPED;
    if      (in_range(a, PROG_RAM_BASE, PROG_RAM_LIMIT)) region = REG_PROG_RAM;
    else if (in_range(a, IN0_BASE,      IN0_LIMIT))      region = REG_IN0;
    else if (in_range(a, DSW0_BASE,     DSW0_LIMIT))     region = REG_DSW0;
    else if (in_range(a, DSW1_BASE,     DSW1_LIMIT))     region = REG_DSW1;
    else if (in_range(a, VGGO_BASE,     VGGO_LIMIT))     region = REG_VGGO;
    else if (in_range(a, VGRST_BASE,    VGRST_LIMIT))    region = REG_VGRST;
    else if (in_range(a, MATH_RD_BASE,  MATH_RD_LIMIT))  region = REG_MATH_RD;
    else if (in_range(a, POKEY_BASE,    POKEY_LIMIT))    region = REG_POKEY;
    else if (in_range(a, MATH_WR_BASE,  MATH_WR_LIMIT))  region = REG_MATH_WR;
    else if (in_range(a, VECTOR_BASE,   VECTOR_LIMIT))   region = REG_VECTOR;
    else if (in_range(a, PROG_ROM_BASE, PROG_ROM_LIMIT)) region = REG_PROG_ROM;
  end

endmodule

// File: rtl/addr_decoder.sv
// -----------------------------------------------------------------------------
// addr_decoder
// CPU address decoder: steers CPU address/data to five BRAM channels, builds
// per-channel write enables, generates vector-generator go/reset strobes and
// muxes CPU read data with one CPU-cycle latency.
// Ports:
//   clk, rst_l (sync, active-low), clk_en (CPU cycle enable, one clk wide)
//   addr[15:0], we, dataFromCore[7:0]           CPU bus
//   halt, clk_3KHz, self_test, coin              IN0 inputs
//   option_switch[15:0]                          DIP switches (DSW0/DSW1)
//   dataFromBram[5][8]                           per-channel read data
//   addrToBram[5][16], dataToBram[5][8], weEnBram[5]  per-channel BRAM bus
//   dataToCore[7:0], vggo, vgrst                 CPU read data, VG strobes
// Configuration:
//   ADDR_DECODER_OPEN_BUS_EN  defined: unmapped reads return the last value
//                             driven for a mapped read; undefined: 8'hFF.
// -----------------------------------------------------------------------------
module addr_decoder
  import addr_decoder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   clk_en,
  input  logic [15:0]            addr,
  input  logic                   we,
  input  logic [7:0]             dataFromCore,
  input  logic                   halt,
  input  logic                   clk_3KHz,
  input  logic                   self_test,
  input  logic                   coin,
  input  logic [15:0]            option_switch,
  input  logic [NUM_CH-1:0][7:0] dataFromBram,
  output logic [NUM_CH-1:0][15:0] addrToBram,
  output logic [NUM_CH-1:0][7:0] dataToBram,
  output logic [NUM_CH-1:0]      weEnBram,
  output logic [7:0]             dataToCore,
  output logic                   vggo,
  output logic                   vgrst
);

  region_t     region;
  region_t     region_q;
  logic [7:0]  in0_q;
  logic [7:0]  dsw0_q;
  logic [7:0]  dsw1_q;
  logic        mapped_hit;
  logic [7:0]  mapped_data;
  logic [7:0]  unmapped_data;

  addr_region_decode u_region (
    .addr   (addr),
    .region (region)
  );

  // Every channel sees the raw CPU address and write data.
  assign addrToBram = {NUM_CH{addr}};
  assign dataToBram = {NUM_CH{dataFromCore}};

  // Write enables. PROG_ROM, IN0 and DSW are read-only; watchdog (1400) and
  // coin counter (1000) writes fall in unmapped space and are simply dropped.
  always_comb begin
    weEnBram = '0;
    if (rst_l && we) begin
      case (region)
        REG_PROG_RAM: weEnBram[CH_PROG_RAM] = 1'b1;
        REG_VECTOR:   weEnBram[CH_VECTOR]   = (addr[14:0] <= VECTOR_WR_LIMIT);
        REG_POKEY:    weEnBram[CH_POKEY]    = 1'b1;
        REG_MATH_WR:  weEnBram[CH_MATH]     = 1'b1;
        default:      ;
      endcase
    end
  end

  assign vggo  = rst_l & clk_en & we & (region == REG_VGGO);
  assign vgrst = rst_l & clk_en & we & (region == REG_VGRST);

  // Region and input ports are captured together so the read mux sees a
  // coherent snapshot for the whole CPU cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      region_q <= REG_UNMAPPED;
      in0_q    <= 8'hFF;
      dsw0_q   <= 8'hFF;
      dsw1_q   <= 8'hFF;
    end else if (clk_en) begin
      region_q <= region;
      in0_q    <= {clk_3KHz, halt, 1'b1, self_test, 1'b1, 1'b1, ~coin, 1'b1};
      dsw0_q   <= option_switch[7:0];
      dsw1_q   <= option_switch[15:8];
    end
  end

  // Strobe-only and write-only ranges are part of the map but read as 8'hFF.
  always_comb begin
    mapped_hit  = 1'b1;
    mapped_data = 8'hFF;
    case (region_q)
      REG_PROG_RAM: mapped_data = dataFromBram[CH_PROG_RAM];
      REG_IN0:      mapped_data = in0_q;
      REG_DSW0:     mapped_data = dsw0_q;
      REG_DSW1:     mapped_data = dsw1_q;
      REG_MATH_RD:  mapped_data = dataFromBram[CH_MATH];
      REG_POKEY:    mapped_data = dataFromBram[CH_POKEY];
      REG_VECTOR:   mapped_data = dataFromBram[CH_VECTOR];
      REG_PROG_ROM: mapped_data = dataFromBram[CH_PROG_ROM];
      REG_VGGO, REG_VGRST, REG_MATH_WR: mapped_data = 8'hFF;
      default:      mapped_hit  = 1'b0;
    endcase
  end

`ifdef ADDR_DECODER_OPEN_BUS_EN
  // Holds the value driven during the CPU cycle that is ending; it becomes
  // visible if the cycle that starts now reads unmapped space.
  logic [7:0] bus_q;
  always_ff @(posedge clk) begin
    if (!rst_l)
      bus_q <= 8'hFF;
    else if (clk_en && mapped_hit)
      bus_q <= mapped_data;
  end
  assign unmapped_data = bus_q;
`else
  assign unmapped_data = 8'hFF;
`endif

  assign dataToCore = !rst_l     ? 8'hFF :
                      mapped_hit ? mapped_data : unmapped_data;

endmodule

// File: tb/tb_addr_decoder.sv
// -----------------------------------------------------------------------------
// tb_addr_decoder
// Self-checking bench for addr_decoder (default build, open bus disabled):
// directed vector table, hand-written reset / enable / IN0 sequences and
// randomized cycles against a range-based reference model.
// -----------------------------------------------------------------------------
module tb_addr_decoder;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             clk_en;
  logic [15:0]      addr;
  logic             we;
  logic [7:0]       dataFromCore;
  logic             halt, clk_3KHz, self_test, coin;
  logic [15:0]      option_switch;
  logic [4:0][7:0]  dataFromBram;
  logic [4:0][15:0] addrToBram;
  logic [4:0][7:0]  dataToBram;
  logic [4:0]       weEnBram;
  logic [7:0]       dataToCore;
  logic             vggo, vgrst;

  int checks = 0;
  int errors = 0;

  addr_decoder dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .clk_en        (clk_en),
    .addr          (addr),
    .we            (we),
    .dataFromCore  (dataFromCore),
    .halt          (halt),
    .clk_3KHz      (clk_3KHz),
    .self_test     (self_test),
    .coin          (coin),
    .option_switch (option_switch),
    .dataFromBram  (dataFromBram),
    .addrToBram    (addrToBram),
    .dataToBram    (dataToBram),
    .weEnBram      (weEnBram),
    .dataToCore    (dataToCore),
    .vggo          (vggo),
    .vgrst         (vgrst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (address map as plain ranges) ----------
  function automatic logic [4:0] model_wen(input int a_full, input bit w);
    int a = a_full & 32'h7FFF;
    if (!w) return 5'b0;
    if (a <= 'h07FF)                return 5'b00010;
    if (a >= 'h2000 && a <= 'h2FFF) return 5'b00100;
    if (a >= 'h1820 && a <= 'h185F) return 5'b10000;
    if (a >= 'h1860 && a <= 'h187F) return 5'b01000;
    return 5'b0;
  endfunction

  function automatic logic [7:0] model_rd(input int a_full);
    int a = a_full & 32'h7FFF;
    if (a <= 'h07FF)                return dataFromBram[1];
    if (a >= 'h0800 && a <= 'h09FF)
      return {clk_3KHz, halt, 1'b1, self_test, 1'b1, 1'b1, ~coin, 1'b1};
    if (a >= 'h0A00 && a <= 'h0BFF) return option_switch[7:0];
    if (a >= 'h0C00 && a <= 'h0DFF) return option_switch[15:8];
    if (a >= 'h1800 && a <= 'h181F) return dataFromBram[3];
    if (a >= 'h1820 && a <= 'h185F) return dataFromBram[4];
    if (a >= 'h2000 && a <= 'h3FFF) return dataFromBram[2];
    if (a >= 'h5000 && a <= 'h7FFF) return dataFromBram[0];
    return 8'hFF;
  endfunction

  function automatic bit model_hit(input int a_full, input int lo, input int hi);
    int a = a_full & 32'h7FFF;
    return a >= lo && a <= hi;
  endfunction

  // One CPU cycle: drive at negedge, sample strobes mid-cycle, sample read
  // data one time step after the following negedge.
  logic [4:0] s_wen;
  logic       s_go, s_rst;
  logic [7:0] s_data;

  task automatic cpu_cycle(input logic [15:0] a, input logic w, input logic en);
    @(negedge clk);
    addr = a; we = w; clk_en = en; dataFromCore = 8'($urandom);
    #2;
    s_wen = weEnBram; s_go = vggo; s_rst = vgrst;
    check("addr_route", 32'(addrToBram[3]), 32'(a));
    @(negedge clk);
    clk_en = 1'b0; we = 1'b0;
    #1;
    s_data = dataToCore;
  endtask

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [7:0]  exp_d;
    logic [4:0]  exp_wen;
    logic        exp_go;
    logic        exp_rst;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_l = 1'b0; clk_en = 1'b0; addr = 16'h0000; we = 1'b0;
    dataFromCore = 8'h00; halt = 1'b0; clk_3KHz = 1'b0; self_test = 1'b1;
    coin = 1'b0; option_switch = 16'hA55A;
    dataFromBram = {8'h44, 8'h33, 8'h22, 8'h11, 8'h5A}; // ch4..ch0

    // ---------------- reset state ----------------
    @(negedge clk);
    addr = 16'h1200; we = 1'b1; clk_en = 1'b1;
    #2;
    check("rst_vggo", 32'(vggo), 0);
    addr = 16'h0000;
    #1;
    check("rst_wen", 32'(weEnBram), 0);
    @(negedge clk);
    check("rst_data", 32'(dataToCore), 32'hFF);
    we = 1'b0; clk_en = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;

    // ---------------- directed vector table ----------------
    vecs = '{
      '{16'h7FFC, 1'b0, 8'h5A, 5'b00000, 1'b0, 1'b0},
      '{16'hFFFC, 1'b0, 8'h5A, 5'b00000, 1'b0, 1'b0},
      '{16'h0000, 1'b0, 8'h11, 5'b00000, 1'b0, 1'b0},
      '{16'h0000, 1'b1, 8'h11, 5'b00010, 1'b0, 1'b0},
      '{16'h2400, 1'b1, 8'h22, 5'b00100, 1'b0, 1'b0},
      '{16'h3400, 1'b1, 8'h22, 5'b00000, 1'b0, 1'b0},
      '{16'h3FFF, 1'b0, 8'h22, 5'b00000, 1'b0, 1'b0},
      '{16'h1860, 1'b1, 8'hFF, 5'b01000, 1'b0, 1'b0},
      '{16'h1840, 1'b1, 8'h44, 5'b10000, 1'b0, 1'b0},
      '{16'h1800, 1'b1, 8'h33, 5'b00000, 1'b0, 1'b0},
      '{16'h181F, 1'b0, 8'h33, 5'b00000, 1'b0, 1'b0},
      '{16'h0A00, 1'b0, 8'h5A, 5'b00000, 1'b0, 1'b0},
      '{16'h0C00, 1'b0, 8'hA5, 5'b00000, 1'b0, 1'b0},
      '{16'h4000, 1'b0, 8'hFF, 5'b00000, 1'b0, 1'b0},
      '{16'h4FFF, 1'b0, 8'hFF, 5'b00000, 1'b0, 1'b0},
      '{16'h1200, 1'b1, 8'hFF, 5'b00000, 1'b1, 1'b0},
      '{16'h1600, 1'b1, 8'hFF, 5'b00000, 1'b0, 1'b1},
      '{16'h1400, 1'b1, 8'hFF, 5'b00000, 1'b0, 1'b0},
      '{16'h1000, 1'b1, 8'hFF, 5'b00000, 1'b0, 1'b0},
      '{16'h5000, 1'b1, 8'h5A, 5'b00000, 1'b0, 1'b0},
      '{16'h0E00, 1'b0, 8'hFF, 5'b00000, 1'b0, 1'b0},
      '{16'h1880, 1'b1, 8'hFF, 5'b00000, 1'b0, 1'b0}
    };
    foreach (vecs[i]) begin
      cpu_cycle(vecs[i].a, vecs[i].w, 1'b1);
      check($sformatf("vec%0d_wen",   i), 32'(s_wen),  32'(vecs[i].exp_wen));
      check($sformatf("vec%0d_vggo",  i), 32'(s_go),   32'(vecs[i].exp_go));
      check($sformatf("vec%0d_vgrst", i), 32'(s_rst),  32'(vecs[i].exp_rst));
      check($sformatf("vec%0d_data",  i), 32'(s_data), 32'(vecs[i].exp_d));
    end

    // ---------------- IN0 bit layout ----------------
    halt = 1'b1; clk_3KHz = 1'b1; self_test = 1'b1; coin = 1'b1;
    cpu_cycle(16'h0800, 1'b0, 1'b1);
    check("in0_coin1", 32'(s_data), 32'hFD);
    coin = 1'b0;
    cpu_cycle(16'h0800, 1'b0, 1'b1);
    check("in0_coin0", 32'(s_data), 32'hFF);
    halt = 1'b0; clk_3KHz = 1'b0; self_test = 1'b0; coin = 1'b1;
    cpu_cycle(16'h09FF, 1'b0, 1'b1);
    check("in0_low", 32'(s_data), 32'h2D);

    // ---------------- no clk_en: no strobe, no new read ----------------
    cpu_cycle(16'h0000, 1'b0, 1'b1);
    check("hold_pre", 32'(s_data), 32'h11);
    cpu_cycle(16'h1200, 1'b1, 1'b0);
    check("noen_vggo", 32'(s_go), 0);
    check("noen_hold", 32'(s_data), 32'h11);
    cpu_cycle(16'h1600, 1'b1, 1'b0);
    check("noen_vgrst", 32'(s_rst), 0);

    // ---------------- reset mid-read ----------------
    cpu_cycle(16'h0000, 1'b0, 1'b1);
    check("mid_pre", 32'(s_data), 32'h11);
    @(negedge clk);
    rst_l = 1'b0; addr = 16'h1600; we = 1'b1; clk_en = 1'b1;
    #2;
    check("mid_vgrst", 32'(vgrst), 0);
    check("mid_vggo", 32'(vggo), 0);
    @(negedge clk);
    #1;
    check("mid_data", 32'(dataToCore), 32'hFF);
    we = 1'b0; clk_en = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;

    // ---------------- randomized cycles vs model ----------------
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic        w;
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range('h1800, 'h187F)) | 16'($urandom_range(0, 1) << 15);
        1:       a = 16'($urandom_range('h0000, 'h0FFF));
        default: a = 16'($urandom);
      endcase
      w = 1'($urandom_range(0, 1));
      for (int c = 0; c < 5; c++) dataFromBram[c] = 8'($urandom);
      option_switch = 16'($urandom);
      halt = 1'($urandom); clk_3KHz = 1'($urandom);
      self_test = 1'($urandom); coin = 1'($urandom);
      cpu_cycle(a, w, 1'b1);
      check($sformatf("rnd_wen@%h", a),  32'(s_wen),  32'(model_wen(int'(a), w)));
      check($sformatf("rnd_go@%h", a),   32'(s_go),   32'(w && model_hit(int'(a), 'h1200, 'h13FF)));
      check($sformatf("rnd_rst@%h", a),  32'(s_rst),  32'(w && model_hit(int'(a), 'h1600, 'h17FF)));
      check($sformatf("rnd_data@%h", a), 32'(s_data), 32'(model_rd(int'(a))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
